// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: issue stage in front of a combinational single-precision
// adder. Operand pairs are queued in a small FIFO, special cases (NaN, inf,
// zero, exact cancellation) are resolved locally, and the remaining pairs are
// sent to the external adder. Results leave in order through valid/ready.
// Optional build macro FP_SEQ_STATS_EN adds op_count / bypass_count outputs.
module fp_add_sequencer #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_a,
  input  logic [XLEN-1:0]          in_b,
  input  logic                     in_sub,
  output logic [XLEN-1:0]          add_a,
  output logic [XLEN-1:0]          add_b,
  input  logic [XLEN-1:0]          add_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_result,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef FP_SEQ_STATS_EN
  ,
  output logic [31:0]              op_count,
  output logic [31:0]              bypass_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [2*XLEN-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [1:0]        r_state;
  logic [XLEN-1:0]   r_opa;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN-1:0]   r_add_a;
  logic [XLEN-1:0]   r_add_b;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;
  logic [3:0]        r_flags;

  logic              w_push;
  logic              w_pop;
  logic              w_a_nan, w_a_inf, w_a_zero;
  logic              w_b_nan, w_b_inf, w_b_zero;
  logic              w_sign_diff;
  logic              w_bypass;
  logic [XLEN-1:0]   w_byp_result;
  logic [3:0]        w_byp_flags;

  assign in_ready   = (r_count < (AW+1)'(DEPTH));
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign fifo_count = r_count;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_flags  = r_flags;

  // Operand storage; B is stored with its sign already flipped for subtraction
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b[XLEN-1] ^ in_sub, in_b[XLEN-2:0]};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operand classification (denormals count as zero)
  assign w_a_nan     = (r_opa[30:23] == 8'hFF) && (r_opa[22:0] != '0);
  assign w_a_inf     = (r_opa[30:23] == 8'hFF) && (r_opa[22:0] == '0);
  assign w_a_zero    = (r_opa[30:23] == 8'h00);
  assign w_b_nan     = (r_opb[30:23] == 8'hFF) && (r_opb[22:0] != '0);
  assign w_b_inf     = (r_opb[30:23] == 8'hFF) && (r_opb[22:0] == '0);
  assign w_b_zero    = (r_opb[30:23] == 8'h00);
  assign w_sign_diff = r_opa[31] ^ r_opb[31];

  // Special-case resolution in priority order; flags are {nan, inf, zero, bypass}
  always_comb begin
    w_bypass     = 1'b1;
    w_byp_result = '0;
    w_byp_flags  = 4'b0001;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_sign_diff)) begin
      w_byp_result = 32'h7FC00000;
      w_byp_flags  = 4'b1001;
    end else if (w_a_inf) begin
      w_byp_result = r_opa;
      w_byp_flags  = 4'b0101;
    end else if (w_b_inf) begin
      w_byp_result = r_opb;
      w_byp_flags  = 4'b0101;
    end else if (w_a_zero && w_b_zero) begin
      w_byp_result = {r_opa[31] & r_opb[31], 31'b0};
      w_byp_flags  = 4'b0011;
    end else if (w_a_zero) begin
      w_byp_result = r_opb;
    end else if (w_b_zero) begin
      w_byp_result = r_opa;
    end else if ((r_opa[30:0] == r_opb[30:0]) && w_sign_diff) begin
      w_byp_result = '0;
      w_byp_flags  = 4'b0011;
    end else begin
      w_bypass = 1'b0;
    end
  end

  // Issue FSM: pop, classify, wait on the adder, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_add_a  <= '0;
      r_add_b  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_opa, r_opb} <= r_mem[r_rd_ptr];
            r_state        <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (w_bypass) begin
            r_result <= w_byp_result;
            r_flags  <= w_byp_flags;
            r_state  <= S_DONE;
          end else begin
            r_add_a <= r_opa;
            r_add_b <= r_opb;
            r_cnt   <= CW'(ADD_LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_result <= add_result;
            r_flags  <= {1'b0, add_result[30:23] == 8'hFF,
                         add_result[30:23] == 8'h00, 1'b0};
            r_state  <= S_DONE;
          end
        end
        default: begin
          if (out_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FP_SEQ_STATS_EN
  logic [31:0] r_op_count;
  logic [31:0] r_bypass_count;

  assign op_count     = r_op_count;
  assign bypass_count = r_bypass_count;

  // Completed-operation counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count     <= '0;
      r_bypass_count <= '0;
    end else if (out_valid && out_ready) begin
      r_op_count <= r_op_count + 1'b1;
      if (r_flags[0]) r_bypass_count <= r_bypass_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Testbench for fp_add_sequencer: behavioural reference queue plus directed
// and randomized stimulus; an in-bench adder model stands in for the adder.
module tb_fp_add_sequencer;

  localparam int DEPTH   = 4;
  localparam int ADD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_add_sequencer #(.XLEN(32), .DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .fifo_count(fifo_count)
  );

  // Stand-in adder: exact for 1.0 + 2.0, otherwise a deterministic scramble
  // that sometimes yields inf/zero exponents to exercise the result flags.
  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    x = (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
    case (x[3:2])
      2'd0:    x = {x[31], 8'hFF, x[22:0]};
      2'd1:    x = {x[31], 8'h00, x[22:0]};
      default: x = x;
    endcase
    return x;
  endfunction

  assign add_result = adder_model(add_a, add_b);

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    bit          is_add;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction
  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction
  function automatic bit is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  // Expected outcome of one operation, straight from the arithmetic rules
  function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] braw, input logic sub);
    exp_t e;
    logic [31:0] b;
    b = {braw[31] ^ sub, braw[30:0]};
    e.a = a; e.b = b; e.is_add = 0; e.res = 0; e.flg = 4'b0001;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[31] != b[31])) begin
      e.res = 32'h7FC00000; e.flg = 4'b1001;
    end else if (is_inf(a) || is_inf(b)) begin
      e.res = is_inf(a) ? a : b; e.flg = 4'b0101;
    end else if (is_zero(a) && is_zero(b)) begin
      e.res = (a[31] && b[31]) ? 32'h80000000 : 32'h0; e.flg = 4'b0011;
    end else if (is_zero(a)) begin
      e.res = b;
    end else if (is_zero(b)) begin
      e.res = a;
    end else if (a[30:0] == b[30:0] && a[31] != b[31]) begin
      e.res = 32'h0; e.flg = 4'b0011;
    end else begin
      e.is_add = 1;
      e.res = adder_model(a, b);
      e.flg = {1'b0, e.res[30:23] == 8'hFF, e.res[30:23] == 8'h00, 1'b0};
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: record accepted pairs, check every presented result
  exp_t        q[$];
  exp_t        e_cur;
  logic [31:0] last_a = 0;
  logic [31:0] last_b = 0;
  int          n_push = 0;
  int          n_pop  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      last_a = 0;
      last_b = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e_cur = q[0];
          chk("out_result", 64'(out_result), 64'(e_cur.res));
          chk("out_flags", 64'(out_flags), 64'(e_cur.flg));
          chk("add_a", 64'(add_a), 64'(e_cur.is_add ? e_cur.a : last_a));
          chk("add_b", 64'(add_b), 64'(e_cur.is_add ? e_cur.b : last_b));
          if (out_ready) begin
            if (e_cur.is_add) begin
              last_a = e_cur.a;
              last_b = e_cur.b;
            end
            void'(q.pop_front());
            n_pop++;
            $display("out #%0d result=%h flags=%b", n_pop, out_result, out_flags);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_op(in_a, in_b, in_sub));
        n_push++;
      end
    end
  end

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:0] = 0;
      1: begin r[30:23] = 8'hFF; r[22:0] = 0; end
      2: begin r[30:23] = 8'hFF; r[22] = 1'b1; end
      3: r[30:23] = 8'h00;
      default: if (r[30:23] == 8'hFF || r[30:23] == 8'h00) r[30:23] = 8'h80;
    endcase
    return r;
  endfunction

  // Single operation from an idle pipeline; checks result, flags and latency
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] exp_res, input logic [3:0] exp_flg, input int exp_lat);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid || n > 20) break;
      @(posedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("dir_result", 64'(out_result), 64'(exp_res));
    chk("dir_flags", 64'(out_flags), 64'(exp_flg));
    @(posedge clk); #1;
    chk("valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, pp0, n;
    logic [31:0] r0;
    logic seen;

    rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_sub = 0; out_ready = 1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Pin the reference model with hand-worked cases
    chk("model_add", 64'({ref_op(32'h3F800000, 32'h40000000, 0).flg, ref_op(32'h3F800000, 32'h40000000, 0).res}), 64'h0_40400000);
    chk("model_infcancel", 64'({ref_op(32'h7F800000, 32'hFF800000, 0).flg, ref_op(32'h7F800000, 32'hFF800000, 0).res}), 64'h9_7FC00000);
    chk("model_zero", 64'({ref_op(32'h0, 32'h40490FDB, 1).flg, ref_op(32'h0, 32'h40490FDB, 1).res}), 64'h1_C0490FDB);
    chk("model_cancel", 64'({ref_op(32'h3FC00000, 32'h3FC00000, 1).flg, ref_op(32'h3FC00000, 32'h3FC00000, 1).res}), 64'h3_00000000);

    // Directed cases
    run_one(32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'b0000, 2 + ADD_LAT);
    chk("dir_add_a", 64'(add_a), 64'h3F800000);
    chk("dir_add_b", 64'(add_b), 64'h40000000);
    run_one(32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 4'b1001, 2);
    chk("inf_add_a_held", 64'(add_a), 64'h3F800000);
    run_one(32'h00000000, 32'h40490FDB, 1, 32'hC0490FDB, 4'b0001, 2);
    run_one(32'h3FC00000, 32'h3FC00000, 1, 32'h00000000, 4'b0011, 2);
    run_one(32'h80000000, 32'h00000000, 1, 32'h80000000, 4'b0011, 2);

    // Backpressure: six back-to-back pushes with the consumer stalled
    out_ready = 0;
    p0 = n_push;
    pp0 = n_pop;
    for (int i = 0; i < 6; i++) begin
      in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom); in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("bp_accepted", 64'(n_push - p0), 64'd5);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_fifo_count", 64'(fifo_count), 64'd4);
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("bp_first_valid", 64'(out_valid), 64'd1);
    r0 = out_result;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held", 64'(out_result), 64'(r0));
    out_ready = 1;
    n = 0;
    while ((n_pop - pp0) < 5 && n < 100) begin @(posedge clk); n++; end
    chk("bp_drained", 64'(n_pop - pp0), 64'd5);
    @(posedge clk); #1;

    // Reset while the adder is in flight and two entries wait behind it
    out_ready = 0;
    in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 0; in_valid = 1;
    @(posedge clk); #1;
    in_a = 32'h40000000; in_b = 32'h40400000;
    @(posedge clk); #1;
    in_a = 32'h40400000; in_b = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_rst_count", 64'(fifo_count), 64'd2);
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_fifo_count", 64'(fifo_count), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1;
    out_ready = 1;
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= out_valid; end
    chk("no_stale_result", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = rand_fp();
      in_b = ($urandom_range(0, 5) == 0) ? in_a : rand_fp();
      in_sub = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin @(posedge clk); #1; n++; end
    chk("rand_drain_empty", 64'(q.size()), 64'd0);
    chk("rand_drain_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
